// File: rtl/bram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bram_rr_arbiter
//
// Purpose:
//   Shares one single-port block RAM between two requesters. Requests are
//   arbitrated round-robin, and a port can hold the RAM across a multi-beat
//   burst by keeping req_last low. Each request is accepted and issued to the
//   RAM in the same cycle. Read data returns exactly one cycle later on the
//   port that issued the read, and responses cannot be stalled.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   rX_req_valid/ready       request handshake (ready is combinational)
//   rX_req_we/last           write enable, final beat of a locked burst
//   rX_req_addr/wdata        word address, write data
//   rX_rsp_valid/rdata       read response (rdata is zero when not valid)
//   ram_en/we/a/di           BRAM control, byte address and write data
//   ram_do                   BRAM read data (the BRAM masks it with EN)
// -----------------------------------------------------------------------------
module bram_rr_arbiter #(
  parameter int DW = 128,
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          r0_req_valid,
  output logic          r0_req_ready,
  input  logic          r0_req_we,
  input  logic          r0_req_last,
  input  logic [AW-1:0] r0_req_addr,
  input  logic [DW-1:0] r0_req_wdata,
  output logic          r0_rsp_valid,
  output logic [DW-1:0] r0_rsp_rdata,
  input  logic          r1_req_valid,
  output logic          r1_req_ready,
  input  logic          r1_req_we,
  input  logic          r1_req_last,
  input  logic [AW-1:0] r1_req_addr,
  input  logic [DW-1:0] r1_req_wdata,
  output logic          r1_rsp_valid,
  output logic [DW-1:0] r1_rsp_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [12:0]   ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e        state_q, state_d;
  // rr_q = 0 means port 0 wins the next tie, rr_q = 1 means port 1 wins.
  logic          rr_q, rr_d;
  logic          rspPend0_q, rspPend0_d;
  logic          rspPend1_q, rspPend1_d;

  logic          grant0, grant1, accept;
  logic          selWe, selLast;
  logic [AW-1:0] selAddr;
  logic [DW-1:0] selWdata;

  // Grant selection, next-state logic and all outputs. Every grant is
  // suppressed while reset is high, so reset silences every output with no
  // extra gating downstream. The pointer is always moved to the port that did
  // not win. A beat accepted inside a lock therefore leaves it where the
  // opening IDLE grant put it, and the closing beat hands the next tie to the
  // other port.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_d    = state_q;
    rr_d       = rr_q;

    case (state_q)
      IDLE: begin
        if (r0_req_valid && (!r1_req_valid || !rr_q)) begin
          grant0 = 1'b1;
        end else if (r1_req_valid) begin
          grant1 = 1'b1;
        end
      end
      LOCK0:   grant0 = r0_req_valid;
      LOCK1:   grant1 = r1_req_valid;
      default: state_d = IDLE;
    endcase

    if (RST) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end

    accept   = grant0 | grant1;
    selWe    = grant1 ? r1_req_we    : r0_req_we;
    selLast  = grant1 ? r1_req_last  : r0_req_last;
    selAddr  = grant1 ? r1_req_addr  : r0_req_addr;
    selWdata = grant1 ? r1_req_wdata : r0_req_wdata;

    if (accept) begin
      rr_d = grant0;
      if (selLast) begin
        state_d = IDLE;
      end else begin
        state_d = grant0 ? LOCK0 : LOCK1;
      end
    end

    rspPend0_d = grant0 && !r0_req_we;
    rspPend1_d = grant1 && !r1_req_we;

    r0_req_ready = grant0;
    r1_req_ready = grant1;
    r0_rsp_valid = rspPend0_q && !RST;
    r1_rsp_valid = rspPend1_q && !RST;
    r0_rsp_rdata = r0_rsp_valid ? ram_do : '0;
    r1_rsp_rdata = r1_rsp_valid ? ram_do : '0;

    // EN must also be held in the response cycle because the BRAM zeroes Do
    // whenever EN is low.
    ram_en = accept | r0_rsp_valid | r1_rsp_valid;
    ram_we = (accept && selWe) ? 4'hF : 4'h0;
    ram_a  = accept ? 13'({selAddr, 2'b00}) : 13'h0000;
    ram_di = accept ? selWdata : '0;
  end

  // State register. A synchronous reset drops any lock and any response still
  // in flight, so no response can appear after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      rspPend0_q <= 1'b0;
      rspPend1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      rspPend0_q <= rspPend0_d;
      rspPend1_q <= rspPend1_d;
    end
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_rr_arbiter
//
// Purpose:
//   Self-checking bench for bram_rr_arbiter. A small BRAM model with
//   registered read data sits behind the DUT, and Do is masked by EN. A
//   behavioural model tracks who owns the RAM, the tie-break pointer, the
//   expected memory contents and the response expected next cycle. It is
//   checked on every cycle, alongside a vector table, hand-written corner
//   sequences and random traffic.
// -----------------------------------------------------------------------------
module tb_bram_rr_arbiter;

  localparam int DW = 128;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          r0_req_valid, r0_req_ready, r0_req_we, r0_req_last;
  logic [AW-1:0] r0_req_addr;
  logic [DW-1:0] r0_req_wdata;
  logic          r0_rsp_valid;
  logic [DW-1:0] r0_rsp_rdata;
  logic          r1_req_valid, r1_req_ready, r1_req_we, r1_req_last;
  logic [AW-1:0] r1_req_addr;
  logic [DW-1:0] r1_req_wdata;
  logic          r1_rsp_valid;
  logic [DW-1:0] r1_rsp_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [12:0]   ram_a;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  int checks = 0;
  int errors = 0;

  bram_rr_arbiter #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_req_we(r0_req_we), .r0_req_last(r0_req_last),
    .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_req_we(r1_req_we), .r1_req_last(r1_req_last),
    .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 CLK = ~CLK;

  // Contents of any word that has never been written.
  function automatic logic [DW-1:0] initPattern(input logic [7:0] a);
    return {16{a}} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  endfunction

  // BRAM model: read-first, registered Do, and Do forced to zero while EN is
  // low.
  logic [DW-1:0] bramMem [int];
  logic [DW-1:0] bramDoReg = '0;

  function automatic logic [DW-1:0] bramRead(input int a);
    return bramMem.exists(a) ? bramMem[a] : initPattern(8'(a));
  endfunction

  always @(posedge CLK) begin
    if (ram_en) begin
      bramDoReg <= bramRead(int'(ram_a[9:2]));
      if (ram_we == 4'hF) bramMem[int'(ram_a[9:2])] = ram_di;
    end
  end

  assign ram_do = ram_en ? bramDoReg : '0;

  // Reference model state: current lock owner (-1 when none), the port that
  // wins the next tie, the expected memory contents, and the response due in
  // the coming cycle.
  int            lockOwner = -1;
  int            rrM = 0;
  int            pendPort = -1;
  logic [DW-1:0] pendData = '0;
  logic [DW-1:0] refMem [int];

  function automatic logic [DW-1:0] refRead(input int a);
    return refMem.exists(a) ? refMem[a] : initPattern(8'(a));
  endfunction

  task automatic checkWide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Works out, from the arbitration rules and the inputs now being driven,
  // which port should be accepted this cycle. It then compares every DUT
  // output with that prediction and advances the model past the next rising
  // edge.
  task automatic checkOutput();
    int            g;
    logic          gWe, gLast;
    logic [7:0]    gAddr;
    logic [DW-1:0] gWd;
    logic          expV0, expV1;
    g = -1;
    if (!RST) begin
      if (lockOwner == 0)                      g = r0_req_valid ? 0 : -1;
      else if (lockOwner == 1)                 g = r1_req_valid ? 1 : -1;
      else if (r0_req_valid && r1_req_valid)   g = rrM;
      else if (r0_req_valid)                   g = 0;
      else if (r1_req_valid)                   g = 1;
    end
    gWe   = (g == 1) ? r1_req_we    : r0_req_we;
    gLast = (g == 1) ? r1_req_last  : r0_req_last;
    gAddr = (g == 1) ? r1_req_addr  : r0_req_addr;
    gWd   = (g == 1) ? r1_req_wdata : r0_req_wdata;
    expV0 = !RST && (pendPort == 0);
    expV1 = !RST && (pendPort == 1);

    checkBit("model_ready0", r0_req_ready, g == 0);
    checkBit("model_ready1", r1_req_ready, g == 1);
    checkBit("model_rsp_valid0", r0_rsp_valid, expV0);
    checkBit("model_rsp_valid1", r1_rsp_valid, expV1);
    checkWide("model_rsp_rdata0", r0_rsp_rdata, expV0 ? pendData : '0);
    checkWide("model_rsp_rdata1", r1_rsp_rdata, expV1 ? pendData : '0);
    checkBit("model_ram_en", ram_en, !RST && (g >= 0 || pendPort >= 0));
    checkWide("model_ram_we", DW'(ram_we), DW'((g >= 0 && gWe) ? 4'hF : 4'h0));
    if (g >= 0) begin
      checkWide("model_ram_a", DW'(ram_a), DW'(gAddr) << 2);
      checkWide("model_ram_di", ram_di, gWd);
    end else if (RST) begin
      checkWide("model_ram_a_rst", DW'(ram_a), '0);
      checkWide("model_ram_di_rst", ram_di, '0);
    end

    if (RST) begin
      lockOwner = -1;
      rrM       = 0;
      pendPort  = -1;
    end else begin
      pendPort = -1;
      if (g >= 0) begin
        if (gWe) begin
          refMem[int'(gAddr)] = gWd;
        end else begin
          pendPort = g;
          pendData = refRead(int'(gAddr));
        end
        rrM       = 1 - g;
        lockOwner = gLast ? -1 : g;
      end
    end
  endtask

  // Drives one cycle of stimulus at the falling edge, then runs the model
  // check. The caller can add its own checks right after this returns,
  // before the next rising edge.
  task automatic applyStimulus(
    input logic rst,
    input logic v0, input logic we0, input logic l0, input logic [7:0] a0, input logic [DW-1:0] d0,
    input logic v1, input logic we1, input logic l1, input logic [7:0] a1, input logic [DW-1:0] d1);
    @(negedge CLK);
    RST          = rst;
    r0_req_valid = v0;  r0_req_we = we0; r0_req_last = l0;
    r0_req_addr  = a0;  r0_req_wdata = d0;
    r1_req_valid = v1;  r1_req_we = we1; r1_req_last = l1;
    r1_req_addr  = a1;  r1_req_wdata = d1;
    #1;
    checkOutput();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, '0, 1'b0, 1'b0, 1'b1, 8'h00, '0);
  endtask

  typedef struct {
    logic       rst;
    logic       v0, we0, l0;
    logic [7:0] a0;
    logic       v1, we1, l1;
    logic [7:0] a1;
    logic       er0, er1, ev0, ev1;
  } vec_t;

  vec_t          vecs[12];
  logic [DW-1:0] patA5, patY;

  initial begin
    // Reset, alternating tie-breaks on back-to-back reads, and then a 4-beat
    // locked write burst from port 1 while port 0 keeps requesting.
    //         rst  v0 we0 l0  a0     v1 we1 l1  a1     er0 er1 ev0 ev1
    vecs[0]  = '{1, 1, 0, 1, 8'h01, 1, 0, 1, 8'h02, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 8'h01, 1, 0, 1, 8'h02, 1, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 1, 8'h01, 1, 0, 1, 8'h02, 0, 1, 1, 0};
    vecs[3]  = '{0, 1, 0, 1, 8'h01, 1, 0, 1, 8'h02, 1, 0, 0, 1};
    vecs[4]  = '{0, 1, 0, 1, 8'h01, 1, 0, 1, 8'h02, 0, 1, 1, 0};
    vecs[5]  = '{0, 1, 0, 1, 8'h01, 1, 1, 0, 8'h20, 1, 0, 0, 1};
    vecs[6]  = '{0, 1, 0, 1, 8'h01, 1, 1, 0, 8'h20, 0, 1, 1, 0};
    vecs[7]  = '{0, 1, 0, 1, 8'h01, 1, 1, 0, 8'h21, 0, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 1, 8'h01, 1, 1, 0, 8'h22, 0, 1, 0, 0};
    vecs[9]  = '{0, 1, 0, 1, 8'h01, 1, 1, 1, 8'h23, 0, 1, 0, 0};
    vecs[10] = '{0, 1, 0, 1, 8'h01, 1, 0, 1, 8'h02, 1, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 1, 8'h00, 0, 0, 1, 8'h00, 0, 0, 1, 0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst,
                    vecs[i].v0, vecs[i].we0, vecs[i].l0, vecs[i].a0, {4{32'hC0DE_0000 | 32'(i)}},
                    vecs[i].v1, vecs[i].we1, vecs[i].l1, vecs[i].a1, {4{32'hBEEF_0000 | 32'(i)}});
      checkBit($sformatf("vec%0d_ready0", i), r0_req_ready, vecs[i].er0);
      checkBit($sformatf("vec%0d_ready1", i), r1_req_ready, vecs[i].er1);
      checkBit($sformatf("vec%0d_rsp_valid0", i), r0_rsp_valid, vecs[i].ev0);
      checkBit($sformatf("vec%0d_rsp_valid1", i), r1_rsp_valid, vecs[i].ev1);
    end

    // A write followed by a read of the same word returns the new data, and
    // EN stays high in the response cycle.
    patA5 = {16{8'hA5}};
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h10, patA5, 1'b0, 1'b0, 1'b1, 8'h00, '0);
    checkWide("wr_ram_a", DW'(ram_a), DW'(13'h0040));
    checkWide("wr_ram_we", DW'(ram_we), DW'(4'hF));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, '0, 1'b0, 1'b0, 1'b1, 8'h00, '0);
    idleCycle();
    checkBit("rd_rsp_valid0", r0_rsp_valid, 1'b1);
    checkWide("rd_rsp_rdata0", r0_rsp_rdata, patA5);
    checkBit("rd_ram_en", ram_en, 1'b1);

    // A read followed by a write of the same word gets the old data. The write
    // lands in the same cycle as the response without corrupting it.
    patY = {4{32'h1234_5678}};
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h03, '0, 1'b0, 1'b0, 1'b1, 8'h00, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, '0, 1'b1, 1'b1, 1'b1, 8'h03, patY);
    checkWide("rw_old_data", r0_rsp_rdata, initPattern(8'h03));
    checkWide("rw_write_we", DW'(ram_we), DW'(4'hF));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h03, '0, 1'b0, 1'b0, 1'b1, 8'h00, '0);
    idleCycle();
    checkWide("rw_new_data", r0_rsp_rdata, patY);

    // Reset lands while a read issued inside a port-0 lock is still in flight.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, '0, 1'b0, 1'b0, 1'b1, 8'h00, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h06, '0, 1'b1, 1'b0, 1'b1, 8'h07, '0);
    checkBit("lock_blocks_port1", r1_req_ready, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h06, '0, 1'b1, 1'b0, 1'b1, 8'h07, '0);
    checkBit("rst_rsp_valid0", r0_rsp_valid, 1'b0);
    checkBit("rst_ram_en", ram_en, 1'b0);
    checkBit("rst_ready0", r0_req_ready, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h06, '0, 1'b1, 1'b0, 1'b1, 8'h07, '0);
    checkBit("post_rst_ready0", r0_req_ready, 1'b1);
    checkBit("post_rst_ready1", r1_req_ready, 1'b0);
    checkBit("post_rst_no_rsp", r0_rsp_valid, 1'b0);
    idleCycle();

    // A long idle stretch with nothing requested keeps the RAM quiet.
    for (int i = 0; i < 10; i++) begin
      idleCycle();
      checkBit($sformatf("idle%0d_ram_en", i), ram_en, 1'b0);
      checkWide($sformatf("idle%0d_ram_we", i), DW'(ram_we), '0);
      checkBit($sformatf("idle%0d_rsp0", i), r0_rsp_valid, 1'b0);
      checkBit($sformatf("idle%0d_rsp1", i), r1_rsp_valid, 1'b0);
    end

    // Random traffic over a handful of addresses to provoke hazards, with
    // occasional resets, checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
                    8'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
                    8'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_rr_arbiter.md
BRAM_RR_ARBITER -- requirements
Module: bram_rr_arbiter

Interface
REQ-001 SHALL have parameters: DW, 128, data width; AW, 8, word-address width (256 words).
REQ-002 SHALL have ports, clock and reset first:
 CLK  in  1  sole clock; all state updates on rising edge
 RST  in  1  reset, synchronous, active-high
 r0_req_valid  in  1  port-0 request valid
 r0_req_ready  out  1  port-0 request accepted this cycle
 r0_req_we  in  1  1 = write, 0 = read
 r0_req_last  in  1  final beat of a locked burst
 r0_req_addr  in  AW  word address
 r0_req_wdata  in  DW  write data
 r0_rsp_valid  out  1  port-0 read data valid
 r0_rsp_rdata  out  DW  port-0 read data
 r1_*  (same seven signals as r0_*, for port 1)
 ram_en  out  1  to BRAM EN
 ram_we  out  4  to BRAM WE
 ram_a  out  13  to BRAM A, byte address
 ram_di  out  DW  to BRAM Di
 ram_do  in  DW  from BRAM Do

Function
REQ-003 SHALL accept at most one request per cycle; rX_req_ready SHALL be combinational and high only for the granted port, and only when rX_req_valid is high; a beat is accepted when valid && ready.
REQ-004 SHALL run an FSM with states IDLE, LOCK0, LOCK1.
REQ-005 In IDLE with one port valid, SHALL grant that port; with both valid, SHALL grant the port selected by the round-robin pointer rr.
REQ-006 On each IDLE acceptance, rr SHALL toggle to the non-granted port.
REQ-007 Accepting a beat with last=0 SHALL move the FSM to LOCKx for the granted port; last=1 SHALL keep it in IDLE.
REQ-008 In LOCKx, SHALL grant only port x, even if the other port is valid; port y gets ready=0.
REQ-009 In LOCKx, accepting a beat with last=1 SHALL return the FSM to IDLE and set rr to the other port.
REQ-010 In LOCKx, cycles with port x valid low SHALL hold the lock.
REQ-011 An accepted beat SHALL drive, in the same cycle: ram_a = {3'b000, addr, 2'b00}; ram_di = wdata; ram_we = 4'hF for a write, 4'h0 for a read.
REQ-012 ram_we SHALL be 4'h0 in every cycle with no accepted write.
REQ-013 ram_en SHALL be high in a cycle when a beat is accepted, or when a read response is due in that cycle.
REQ-014 ram_en SHALL otherwise be 0; the BRAM masks Do with EN, so EN is required in the response cycle.
REQ-015 Read latency SHALL be exactly 1: a read accepted in cycle N gives rX_rsp_valid=1 in cycle N+1, and only on the issuing port.
REQ-016 rX_rsp_rdata SHALL equal ram_do while rX_rsp_valid=1, and SHALL be 0 otherwise.
REQ-017 Responses SHALL have no backpressure.
REQ-018 Back-to-back reads SHALL sustain 1 beat/cycle, and the response pipe SHALL overlap with new issue.
REQ-019 A write accepted in cycle N to address a, followed by a read of a accepted in N+1, SHALL return the new data in N+2.
REQ-020 A read of a in N followed by a write of a in N+1 SHALL return the old data in N+1.
REQ-021 A write accepted in the same cycle as a read response SHALL not corrupt that response.

Reset
REQ-022 While RST=1 at a rising edge, SHALL set: FSM=IDLE, rr=port 0, response-pending flags cleared.
REQ-023 During reset, outputs SHALL be: r0/r1_req_ready=0, rsp_valid=0, rsp_rdata=0, ram_en=0, ram_we=4'h0, ram_a=0, ram_di=0.
REQ-024 Reset asserted mid-burst or with a read in flight SHALL drop the lock and the pending response; no rsp_valid SHALL appear after reset deasserts.
REQ-025 In the first cycle after reset deasserts with both ports valid, port 0 SHALL be granted.

Verification
REQ-026 Arbitration: after reset, both ports issue single-beat reads (last=1) every cycle. Required: grants alternate 0,1,0,1; each port's rsp_valid pulses one cycle after its grant.
REQ-027 Write/read: port 0 writes 128'hA5..A5 to addr 8'h10. Required: ram_a=13'h0040, ram_we=4'hF. A port-0 read of 8'h10 in the next cycle returns 128'hA5..A5 one cycle later, with ram_en=1 in that cycle.
REQ-028 Lock: port 1 issues a 4-beat write burst, last on beat 4, while port 0 is continuously valid. Required: r0_req_ready=0 for all 4 beats; port 0 granted in the cycle after beat 4.
REQ-029 Read then write: port 0 reads addr 3 (contents X) while port 1 writes Y to addr 3 in the next cycle. Required: port 0 receives X; a later read returns Y.
REQ-030 Reset mid-operation: assert RST the cycle after a read accept inside a LOCK0 burst. Required: rsp_valid=0 and ram_en=0 during reset; FSM in IDLE afterwards; port 0 granted first when both ports are valid.
REQ-031 Idle: no valid on either port for 10 cycles. Required: ram_en=0, ram_we=0, both rsp_valid=0 throughout.
